// File: rtl/target_dsm_ramp.sv
// Slew-limited setpoint tracker feeding a first-order delta-sigma bitstream.
// The setpoint chases the last loaded target by at most SLEW_STEP per TICK_DIV clocks.
module target_dsm_ramp #(
    parameter logic [31:0] SLEW_STEP = 32'd4295,
    parameter int          TICK_DIV  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] target,
    input  logic        load,
    output logic [31:0] setpoint,
    output logic        settled,
    output logic        pwm_out
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   req_q, req_d;
    logic [31:0]   sp_q, sp_d;
    logic [31:0]   acc_q;
    logic [TW-1:0] tick_q, tick_d;
    logic          pwm_q;

    logic          tick_last;
    logic [32:0]   diff33;
    logic          up;
    logic [31:0]   mag, step;
    logic [32:0]   sum;

    assign tick_last = (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        diff33 = {1'b0, req_q} - {1'b0, sp_q};
        up     = ~diff33[32];
        mag    = up ? diff33[31:0] : (sp_q - req_q);
        step   = (mag < SLEW_STEP) ? mag : SLEW_STEP;
        sum    = {1'b0, acc_q} + {1'b0, sp_q};
    end

    always_comb begin
        state_d = state_q;
        req_d   = load ? target : req_q;
        sp_d    = sp_q;
        tick_d  = tick_q;

        // A step on the same edge as a load still heads for the old request.
        if (state_q == RAMP && tick_last)
            sp_d = up ? (sp_q + step) : (sp_q - step);

        // Settled exactly when the setpoint agrees with the request it will hold.
        state_d = (sp_d != req_d) ? RAMP : IDLE;

        if (state_q == IDLE || state_d == IDLE)
            tick_d = '0;
        else
            tick_d = tick_last ? '0 : tick_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            sp_q    <= '0;
            tick_q  <= '0;
            acc_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sp_q    <= sp_d;
            tick_q  <= tick_d;
            acc_q   <= sum[31:0];
            pwm_q   <= sum[32];
        end
    end

    assign setpoint = sp_q;
    assign settled  = (state_q == IDLE);
    assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_target_dsm_ramp.sv
// Directed bench: slew timing, retarget, async reset, no-op load, modulator density, full scale.
module tb_target_dsm_ramp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] target = '0;
    logic        load_a = 1'b0, load_5 = 1'b0, load_6 = 1'b0;
    logic [31:0] sp_a, sp_5, sp_6;
    logic        st_a, st_5, st_6;
    logic        pwm_a, pwm_5, pwm_6;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    target_dsm_ramp #(.SLEW_STEP(32'd1000), .TICK_DIV(4)) u_a (
        .clk(clk), .reset(reset), .target(target), .load(load_a),
        .setpoint(sp_a), .settled(st_a), .pwm_out(pwm_a));

    target_dsm_ramp #(.SLEW_STEP(32'h4000_0000), .TICK_DIV(2)) u_5 (
        .clk(clk), .reset(reset), .target(target), .load(load_5),
        .setpoint(sp_5), .settled(st_5), .pwm_out(pwm_5));

    target_dsm_ramp #(.SLEW_STEP(32'h8000_0000), .TICK_DIV(4)) u_6 (
        .clk(clk), .reset(reset), .target(target), .load(load_6),
        .setpoint(sp_6), .settled(st_6), .pwm_out(pwm_6));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge following the capturing edge.
    task automatic do_load(input int which, input logic [31:0] t);
        @(negedge clk);
        target = t;
        case (which)
            0:       load_a = 1'b1;
            5:       load_5 = 1'b1;
            default: load_6 = 1'b1;
        endcase
        @(negedge clk);
        load_a = 1'b0;
        load_5 = 1'b0;
        load_6 = 1'b0;
    endtask

    initial begin
        int ones, win, bad, same, drops;
        logic prev;

        #12;
        chk("rst_sp", sp_a, 32'd0);
        chk("rst_settled", 32'(st_a), 32'd1);
        chk("rst_pwm", 32'(pwm_a), 32'd0);
        @(negedge clk) reset = 1'b0;

        // async reset mid-ramp
        do_load(0, 32'd5000);
        chk("t1_settled_drop", 32'(st_a), 32'd0);
        cyc(8);
        chk("t1_sp_2000", sp_a, 32'd2000);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_sp", sp_a, 32'd0);
        chk("t1_async_settled", 32'(st_a), 32'd1);
        chk("t1_async_pwm", 32'(pwm_a), 32'd0);
        @(negedge clk) reset = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            ones += int'(pwm_a);
        end
        chk("t1_post_pwm_ones", 32'(ones), 32'd0);
        chk("t1_post_settled", 32'(st_a), 32'd1);
        chk("t1_post_sp", sp_a, 32'd0);

        // retarget mid-ramp at tick_cnt==1
        do_load(0, 32'd5000);
        cyc(8);
        chk("t3_sp_2000", sp_a, 32'd2000);
        @(posedge clk);
        do_load(0, 32'd500);
        cyc(2);
        chk("t3_step_1000", sp_a, 32'd1000);
        chk("t3_settled_0", 32'(st_a), 32'd0);
        cyc(3);
        chk("t3_hold_1000", sp_a, 32'd1000);
        cyc(1);
        chk("t3_land_500", sp_a, 32'd500);
        chk("t3_settled_1", 32'(st_a), 32'd1);

        // up-ramp from 0
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        do_load(0, 32'd2500);
        chk("t2_settled_k", 32'(st_a), 32'd0);
        cyc(3);
        chk("t2_sp_k3", sp_a, 32'd0);
        cyc(1);
        chk("t2_sp_k4", sp_a, 32'd1000);
        cyc(4);
        chk("t2_sp_k8", sp_a, 32'd2000);
        cyc(3);
        chk("t2_sp_k11", sp_a, 32'd2000);
        chk("t2_settled_k11", 32'(st_a), 32'd0);
        cyc(1);
        chk("t2_sp_k12", sp_a, 32'd2500);
        chk("t2_settled_k12", 32'(st_a), 32'd1);

        // no-op load
        do_load(0, 32'd2500);
        drops = st_a ? 0 : 1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (!st_a) drops++;
        end
        chk("t4_settled_drops", 32'(drops), 32'd0);
        chk("t4_sp", sp_a, 32'd2500);

        // modulator density, quarter scale
        do_load(5, 32'h4000_0000);
        cyc(2);
        chk("t5_sp_q", sp_5, 32'h4000_0000);
        chk("t5_settled_q", 32'(st_5), 32'd1);
        cyc(4);
        ones = 0; win = 0; bad = 0;
        for (int i = 0; i < 4096; i++) begin
            cyc(1);
            ones += int'(pwm_5);
            win  += int'(pwm_5);
            if (i % 4 == 3) begin
                if (win != 1) bad++;
                win = 0;
            end
        end
        chk("t5_ones_q", 32'(ones), 32'd1024);
        chk("t5_bad_windows", 32'(bad), 32'd0);

        // half scale
        do_load(5, 32'h8000_0000);
        cyc(2);
        chk("t5_sp_h", sp_5, 32'h8000_0000);
        cyc(4);
        ones = 0; same = 0; prev = pwm_5;
        for (int i = 0; i < 4096; i++) begin
            cyc(1);
            ones += int'(pwm_5);
            if (pwm_5 == prev) same++;
            prev = pwm_5;
        end
        chk("t5_ones_h", 32'(ones), 32'd2048);
        chk("t5_not_alternating", 32'(same), 32'd0);

        // full-scale up and down
        do_load(6, 32'hFFFF_FFFF);
        cyc(4);
        chk("t6_up_1", sp_6, 32'h8000_0000);
        cyc(4);
        chk("t6_up_2", sp_6, 32'hFFFF_FFFF);
        chk("t6_up_settled", 32'(st_6), 32'd1);
        do_load(6, 32'd0);
        cyc(4);
        chk("t6_dn_1", sp_6, 32'h7FFF_FFFF);
        cyc(4);
        chk("t6_dn_2", sp_6, 32'd0);
        chk("t6_dn_settled", 32'(st_6), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
